// File: rtl/rle_decoder_if.sv
// Token-in / bit-out handshake bundle for the run-length decoder.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the token side, out_valid/out_ready on the bit side.
// Ports: in_valid, in_ready, in_bit, in_count[CNT_W], in_last, out_valid, out_ready,
//        out_bit, out_last. master = producer/consumer side, slave = decoder side.
interface rle_decoder_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic [CNT_W-1:0] in_count;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             out_last;

   modport master (
      output in_valid, in_bit, in_count, in_last, out_ready,
      input  in_ready, out_valid, out_bit, out_last
   );

   modport slave (
      input  in_valid, in_bit, in_count, in_last, out_ready,
      output in_ready, out_valid, out_bit, out_last
   );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (bit, count) tokens into a serial bit stream, one bit per transfer.
// Latency: token accepted at edge N presents its first bit from edge N; count c gives c+1 bits.
// Backpressure: out_ready=0 freezes all state; in_ready is combinational from out_ready so runs chain with no bubble.
// Ports: clock, reset (async, active-high), bus (rle_decoder_if.slave).
// Option: define RLE_DEC_TOGGLE_EN to take run polarity from an internal phase that flips per
//         token and restarts at 0 after a frame's last token; in_bit is then ignored.
module rle_decoder #(
   parameter int CNT_W = 8
) (
   input  logic          clock,
   input  logic          reset,
   rle_decoder_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;   // bits left after the one being presented
   logic             bit_q, bit_d;
   logic             last_q, last_d;
   logic             run_value;
   logic             accept;
   logic             transfer;
   logic             remain_zero;

`ifdef RLE_DEC_TOGGLE_EN
   logic             phase_q, phase_d;
   assign run_value = phase_q;
`else
   assign run_value = bus.in_bit;
`endif

   assign remain_zero   = (remain_q == '0);
   assign bus.out_valid = (state_q == RUN);
   assign bus.out_bit   = bit_q;
   assign bus.out_last  = bus.out_valid && remain_zero && last_q;
   // The final bit of a run and the next token's load share one edge.
   assign bus.in_ready  = (state_q == IDLE) || (remain_zero && bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign transfer      = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      bit_d    = bit_q;
      last_d   = last_q;
`ifdef RLE_DEC_TOGGLE_EN
      phase_d  = phase_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = RUN;
               remain_d = bus.in_count;
               bit_d    = run_value;
               last_d   = bus.in_last;
            end
         end
         RUN: begin
            if (transfer) begin
               if (!remain_zero) begin
                  remain_d = remain_q - 1'b1;
               end else if (accept) begin
                  remain_d = bus.in_count;
                  bit_d    = run_value;
                  last_d   = bus.in_last;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef RLE_DEC_TOGGLE_EN
      // Each frame starts with a 0-run, so a frame-ending token re-arms phase to 0.
      if (accept) begin
         phase_d = bus.in_last ? 1'b0 : ~phase_q;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         remain_q <= '0;
         bit_q    <= 1'b0;
         last_q   <= 1'b0;
`ifdef RLE_DEC_TOGGLE_EN
         phase_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         bit_q    <= bit_d;
         last_q   <= last_d;
`ifdef RLE_DEC_TOGGLE_EN
         phase_q  <= phase_d;
`endif
      end
   end

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: vector table, directed multi-cycle sequences,
// and randomized traffic against a queue-of-bits reference model.
module tb_rle_decoder;
   localparam int CNT_W = 8;
`ifdef RLE_DEC_TOGGLE_EN
   localparam bit TOGGLE = 1'b1;
`else
   localparam bit TOGGLE = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;

   rle_decoder_if #(.CNT_W(CNT_W)) bus ();
   rle_decoder #(.CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic iv; logic ib; logic [CNT_W-1:0] ic; logic il; logic ordy;
      logic ev; logic eb; logic el; logic erdy;
   } vec_t;

   typedef struct { logic b; logic l; } ebit_t;

   vec_t  tbl [14];
   ebit_t exp_q [$];
   ebit_t eb;
   logic  got_q [$];
   logic  m_phase;
   logic  t_v, t_b, t_l, drain, e_v, e_r, xfer, acc, val;
   logic [CNT_W-1:0] t_c;
   int    pending, xfers, tok_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic b, input logic [CNT_W-1:0] c,
                        input logic l, input logic r);
      bus.in_valid  = v;
      bus.in_bit    = b;
      bus.in_count  = c;
      bus.in_last   = l;
      bus.out_ready = r;
   endtask

   // Polarity of the first run after reset.
   function automatic logic first_val(input logic b);
      return TOGGLE ? 1'b0 : b;
   endfunction

   task automatic do_reset();
      drive(0, 0, '0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      @(negedge clock);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_bit",   bus.out_bit,   0);
      chk("rst_out_last",  bus.out_last,  0);
      chk("rst_in_ready",  bus.in_ready,  1);
      reset = 1'b0;
      tick();
   endtask

   initial begin
      // {in_valid, in_bit, in_count, in_last, out_ready, exp out_valid, out_bit, out_last, in_ready}
      tbl[0]  = '{1, 1, 3, 1, 1,  0, 0, 0, 1};
      tbl[1]  = '{0, 0, 0, 0, 1,  1, 1, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 1,  1, 1, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 1,  1, 1, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 1,  1, 1, 1, 1};
      tbl[5]  = '{0, 0, 0, 0, 1,  0, 0, 0, 1};
      tbl[6]  = '{1, 1, 0, 0, 1,  0, 0, 0, 1};
      tbl[7]  = '{1, 0, 2, 0, 1,  1, 1, 0, 1};
      tbl[8]  = '{1, 1, 1, 1, 1,  1, 0, 0, 0};
      tbl[9]  = '{1, 1, 1, 1, 1,  1, 0, 0, 0};
      tbl[10] = '{1, 1, 1, 1, 1,  1, 0, 0, 1};
      tbl[11] = '{0, 0, 0, 0, 1,  1, 1, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 1,  1, 1, 1, 1};
      tbl[13] = '{0, 0, 0, 0, 1,  0, 0, 0, 1};

      do_reset();

`ifndef RLE_DEC_TOGGLE_EN
      // Single run then back-to-back runs, cycle by cycle.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iv, tbl[i].ib, tbl[i].ic, tbl[i].il, tbl[i].ordy);
         @(negedge clock);
         chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_in_ready", i),  bus.in_ready,  tbl[i].erdy);
         chk($sformatf("tbl%0d_out_last", i),  bus.out_last,  tbl[i].el);
         if (tbl[i].ev) chk($sformatf("tbl%0d_out_bit", i), bus.out_bit, tbl[i].eb);
         tick();
      end
`else
      // Toggle mode: counts 1,0,2(last),0 with in_bit=1 on the 4th -> 0,0,1,0,0,0,0.
      begin
         logic [CNT_W-1:0] tc [4];
         logic tl [4];
         logic ex [7];
         tc = '{1, 0, 2, 0};
         tl = '{0, 0, 1, 0};
         ex = '{0, 0, 1, 0, 0, 0, 0};
         tok_idx = 0;
         got_q.delete();
         for (int cyc = 0; cyc < 30; cyc++) begin
            if (tok_idx < 4) drive(1, (tok_idx == 3), tc[tok_idx], tl[tok_idx], 1);
            else             drive(0, 0, '0, 0, 1);
            @(negedge clock);
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_bit);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) tok_idx++;
         end
         chk("tog_bit_count", got_q.size(), 7);
         for (int i = 0; i < 7; i++)
            if (i < got_q.size()) chk($sformatf("tog_bit%0d", i), got_q[i], ex[i]);
      end
`endif

      // Token (0,5) under out_ready pattern 1,0,0 repeating.
      do_reset();
      drive(1, 0, 5, 1, 1);
      @(negedge clock);
      chk("stall_accept_ready", bus.in_ready, 1);
      tick();
      xfers = 0;
      for (int k = 0; k < 40; k++) begin
         drive(0, 0, '0, 0, (k % 3 == 0));
         @(negedge clock);
         if (bus.out_valid) begin
            chk("stall_out_bit",  bus.out_bit,  first_val(0));
            chk("stall_out_last", bus.out_last, (xfers == 5));
            chk("stall_in_ready", bus.in_ready, (xfers == 5) && bus.out_ready);
         end
         if (bus.out_valid && bus.out_ready) xfers++;
         tick();
      end
      chk("stall_xfers", xfers, 6);

      // Maximum run length.
      do_reset();
      drive(1, 1, '1, 1, 1);
      tick();
      drive(0, 0, '0, 0, 1);
      xfers = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         if (bus.out_valid) begin
            xfers++;
            chk("max_out_bit",  bus.out_bit,  first_val(1));
            chk("max_out_last", bus.out_last, (xfers == 256));
         end
         tick();
      end
      chk("max_xfers", xfers, 256);
      @(negedge clock);
      chk("max_idle_valid", bus.out_valid, 0);
      chk("max_idle_ready", bus.in_ready,  1);
      tick();

      // Reset in the middle of a 5-bit run.
      do_reset();
      drive(1, 1, 4, 0, 1);
      tick();
      drive(0, 0, '0, 0, 1);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_last",  bus.out_last,  0);
      chk("midrst_out_bit",   bus.out_bit,   0);
      chk("midrst_in_ready",  bus.in_ready,  1);
      tick();
      reset = 1'b0;
      tick();
      drive(1, 1, 0, 0, 1);
      tick();
      drive(0, 0, '0, 0, 1);
      xfers = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (bus.out_valid) begin
            xfers++;
            chk("midrst_new_bit", bus.out_bit, first_val(1));
         end
         tick();
      end
      chk("midrst_new_xfers", xfers, 1);

      // Randomized traffic against a queue of expected bits.
      do_reset();
      exp_q.delete();
      m_phase = 1'b0;
      t_v = 1'b0; t_b = 1'b0; t_c = '0; t_l = 1'b0;
      for (int cyc = 0; cyc < 3600; cyc++) begin
         drain = (cyc >= 3000);
         if (!t_v && !drain && $urandom_range(0, 2) != 0) begin
            t_v = 1'b1;
            t_b = 1'($urandom_range(0, 1));
            t_c = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 255))
                                               : CNT_W'($urandom_range(0, 6));
            t_l = ($urandom_range(0, 3) == 0);
         end
         drive(t_v, t_b, t_c, t_l, drain || ($urandom_range(0, 3) != 0));
         @(negedge clock);
         pending = exp_q.size();
         e_v = (pending > 0);
         e_r = (pending == 0) || (pending == 1 && bus.out_ready);
         chk("rnd_out_valid", bus.out_valid, e_v);
         chk("rnd_in_ready",  bus.in_ready,  e_r);
         if (e_v) begin
            chk("rnd_out_bit",  bus.out_bit,  exp_q[0].b);
            chk("rnd_out_last", bus.out_last, exp_q[0].l);
         end
         xfer = e_v && bus.out_ready;
         acc  = t_v && e_r;
         tick();
         if (xfer) void'(exp_q.pop_front());
         if (acc) begin
            val = TOGGLE ? m_phase : t_b;
            for (int i = 0; i <= int'(t_c); i++) begin
               eb.b = val;
               eb.l = t_l && (i == int'(t_c));
               exp_q.push_back(eb);
            end
            m_phase = t_l ? 1'b0 : ~m_phase;
            t_v = 1'b0;
         end
      end
      @(negedge clock);
      chk("rnd_drained_valid", bus.out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Run-length decoder for the RLE datapath: accepts (bit, count) run tokens on a valid/ready input and expands each into a serial bit stream on a valid/ready output, one bit per transfer. It is the expansion side of the RLE path, sitting downstream of token storage and feeding bit-serial consumers. An optional compile-time mode implies run polarity by toggling instead of carrying it in the token.

## Interface
- `CNT_W`, 8: width of the token count field; maximum run length is 2^CNT_W bits.
- `clock` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: token present.
- `in_ready` output 1: decoder accepts the token this cycle.
- `in_bit` input 1: run value; ignored when `RLE_DEC_TOGGLE_EN` is defined.
- `in_count` input CNT_W: run length minus one; 0 means 1 bit, all-ones means 2^CNT_W bits.
- `in_last` input 1: token is the final run of a frame.
- `out_valid` output 1: output bit present.
- `out_ready` input 1: consumer takes the bit this cycle.
- `out_bit` output 1: current expanded bit.
- `out_last` output 1: current bit is the final bit of a frame.

## Operation
- Token accepted when `in_valid && in_ready`. Bit transferred when `out_valid && out_ready`.
- Registers: `state` (IDLE/RUN), `remain` (CNT_W, bits left after the presented bit), `out_bit`, `last_flag`, `phase` (toggle mode only).
- `in_ready` = (state==IDLE) || (remain==0 && out_ready). This is combinational from `out_ready` and allows back-to-back runs with no bubble.
- `out_valid` = (state==RUN). `out_last` = out_valid && remain==0 && last_flag.
- IDLE -> RUN on token accept. Load `remain`<=in_count, `out_bit`<=run value, `last_flag`<=in_last.
- RUN, on transfer with remain!=0: `remain` decrements. `out_bit` and `last_flag` hold.
- RUN, on transfer with remain==0:
  - If a token is accepted the same cycle, load it and stay in RUN.
  - Otherwise go to IDLE.
- RUN with no transfer (out_ready=0): all state holds. `out_bit`, `out_last` and `out_valid` are stable until transferred.
- Counter arithmetic is CNT_W-bit unsigned. `remain` never decrements below 0, because the remain==0 path reloads or idles.
- Reset while RUN: the partial run is discarded. Outputs return to reset values immediately (asynchronously).

## Timing
- Reset values: `out_valid`=0, `out_bit`=0, `out_last`=0, `remain`=0, `last_flag`=0, `phase`=0, state=IDLE. `in_ready`=1 while IDLE.
- Latency: a token accepted at edge N presents its first bit from edge N (visible in the cycle after N).
- A run with count c occupies exactly c+1 output transfers.
- Throughput: one bit per cycle when `out_ready` is held high, including across token boundaries.
- The next token is accepted in the same cycle as the final bit of the current run.

## Configuration
- `RLE_DEC_TOGGLE_EN` defined:
  - Run value = `phase`; `in_bit` is ignored.
  - `phase` flips on every token accept.
  - `phase` is forced to 0 after accepting a token with `in_last`=1, so every frame's first run is 0.
- `RLE_DEC_TOGGLE_EN` undefined:
  - Run value = `in_bit`.
  - No `phase` register exists.

## Test plan
- Reset, then token (bit=1, count=3, last=1) with out_ready=1. Expect out_bit=1 for exactly 4 cycles, `out_last`=1 on the 4th only, then out_valid=0 and in_ready=1.
- Back-to-back tokens (1,0), (0,2), (1,1) with in_valid and out_ready held high. Expect the stream 1,0,0,0,1,1 with no idle cycle, and in_ready pulsing on each run's final bit.
- Token (0,5) with out_ready toggling 1,0,0,1,... Expect exactly 6 transfers, `out_bit`/`remain` holding during stalls, and in_ready=0 until the final bit transfers.
- Token count=all-ones (255, CNT_W=8). Expect exactly 256 transfers, then IDLE.
- Assert reset mid-run after 2 of 5 bits. Expect out_valid=0 immediately; a new token (1,0) afterwards yields a single bit 1.
- With `RLE_DEC_TOGGLE_EN`: tokens counts 1,0,2 (last on the 3rd), then 0 with in_bit=1. Expect 0,0,1,0,0,0 then 0, confirming `in_bit` is ignored and phase resets at frame end.
